// File: rtl/el_pkg.sv
// rtl/el_pkg.sv - shared types and helpers for the elastic-link sync/async bridges
package el_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } el_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A digit needs at least one bit even for a single-rail code.
   function automatic int digit_w(input int rail_num);
      return (clog2(rail_num) < 1) ? 1 : clog2(rail_num);
   endfunction

   // Rail r of digit i sits at this bit of the link.
   function automatic int rail_bit(input int rail_num, input int i, input int r);
      return rail_num * i + r;
   endfunction

endpackage

// File: rtl/el_sync_bit.sv
// rtl/el_sync_bit.sv - multi-stage flop synchroniser for one asynchronous bit
module el_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic q_next_o
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift the asynchronous input one stage deeper on every edge.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d_i};
   end

   // Chain flops, cleared together with the rest of the link.
   always_ff @(posedge clk) begin
      if (rst) chain_q <= '0;
      else     chain_q <= chain_d;
   end

   assign q_o      = chain_q[STAGES-1];
   // Value the output will take after the next edge; lets the owner register
   // decisions that depend on the synchronised bit one cycle ahead.
   assign q_next_o = chain_q[STAGES-2];

endmodule

// File: rtl/el_sync_tx.sv
// rtl/el_sync_tx.sv - clocked word source injecting 2-phase 1-of-N tokens into an elastic link
module el_sync_tx
   import el_pkg::*;
#(
   parameter int LINK_WIDTH  = 2,
   parameter int RAIL_NUM    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [LINK_WIDTH*digit_w(RAIL_NUM)-1:0]  in_data,
   output logic [LINK_WIDTH*RAIL_NUM-1:0]           out,
   input  logic                                     ack_i,
   output logic                                     busy,
   output logic                                     err,
   output logic [CNT_W-1:0]                         tx_count
);

   localparam int DIGIT_W = digit_w(RAIL_NUM);
   localparam int DW1     = DIGIT_W + 1;
   localparam int OUT_W   = LINK_WIDTH * RAIL_NUM;

   el_state_e         state_q,    state_d;
   logic [OUT_W-1:0]  out_q,      out_d;
   logic              phase_exp_q, phase_exp_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q,     busy_d;
   logic              err_q,      err_d;
   logic [CNT_W-1:0]  tx_count_q, tx_count_d;

   logic              ack_s;
   logic              ack_s_next;
   logic              accept;
   logic [OUT_W-1:0]  mask;
   logic [LINK_WIDTH-1:0] digit_bad;

   el_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk      (clk),
      .rst      (rst),
      .d_i      (ack_i),
      .q_o      (ack_s),
      .q_next_o (ack_s_next)
   );

   // One transition mask bit per digit; a digit with no matching rail is flagged bad.
   for (genvar gi = 0; gi < LINK_WIDTH; gi++) begin : g_digit
      logic [DIGIT_W-1:0] digit;
      assign digit         = in_data[DIGIT_W*gi +: DIGIT_W];
      assign digit_bad[gi] = ({1'b0, digit} >= DW1'(RAIL_NUM));
      for (genvar gr = 0; gr < RAIL_NUM; gr++) begin : g_rail
         assign mask[rail_bit(RAIL_NUM, gi, gr)] = (digit == DIGIT_W'(gr));
      end
   end

   // Token handshake: launch on accept, retire when the synchronised ack matches.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      phase_exp_d = phase_exp_q;
      tx_count_d  = tx_count_q;
      err_d       = 1'b0;
      accept      = in_valid && in_ready_q;
      case (state_q)
         IDLE: begin
            if (ack_s != phase_exp_q) begin
               // Ack moved with nothing outstanding: flag it and follow the link.
               err_d       = 1'b1;
               phase_exp_d = ack_s;
            end else if (accept) begin
               if (|digit_bad) begin
                  err_d = 1'b1;
               end else begin
                  out_d       = out_q ^ mask;
                  phase_exp_d = ~phase_exp_q;
                  state_d     = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (ack_s == phase_exp_q) begin
               state_d    = IDLE;
               tx_count_d = tx_count_q + 1'b1;
            end
         end
      endcase
      // Ready next cycle only if idle and no spurious ack will be visible then.
      in_ready_d = (state_d == IDLE) && (ack_s_next == phase_exp_d);
      busy_d     = (state_d == WAIT_ACK);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_q       <= '0;
         phase_exp_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         tx_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         phase_exp_q <= phase_exp_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         tx_count_q  <= tx_count_d;
      end
   end

   assign out      = out_q;
   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign tx_count = tx_count_q;

endmodule

// File: tb/tb_el_sync_tx.sv
// tb/tb_el_sync_tx.sv - self-checking bench for el_sync_tx with a behavioural link model
module tb_el_sync_tx;

   localparam int S = 2;

   logic        clk;
   logic        rst;

   logic        in_valid_a, in_ready_a, ack_a, busy_a, err_a;
   logic [1:0]  in_data_a;
   logic [3:0]  out_a;
   logic [15:0] tx_a;

   logic        in_valid_b, in_ready_b, ack_b, busy_b, err_b;
   logic [3:0]  in_data_b;
   logic [5:0]  out_b;
   logic [1:0]  tx_b;

   int checks   = 0;
   int failures = 0;
   bit mdl_en   = 0;

   el_sync_tx #(.LINK_WIDTH(2), .RAIL_NUM(2), .SYNC_STAGES(S), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data_a), .out(out_a), .ack_i(ack_a), .busy(busy_a),
      .err(err_a), .tx_count(tx_a)
   );

   el_sync_tx #(.LINK_WIDTH(2), .RAIL_NUM(3), .SYNC_STAGES(S), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data_b), .out(out_b), .ack_i(ack_b), .busy(busy_b),
      .err(err_b), .tx_count(tx_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of instance A: the link ack is seen S edges late;
   // a token is outstanding from launch until the delayed ack matches its phase.
   bit [3:0]  m_out;
   bit        m_pend, m_phase, m_err, m_ready;
   bit [15:0] m_cnt;
   bit        hist [S];
   bit        acks;
   int        dg;

   always @(posedge clk) begin
      acks = hist[S-1];
      for (int k = S - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ack_a;
      if (rst) begin
         m_out = '0; m_pend = 0; m_phase = 0; m_err = 0; m_ready = 0; m_cnt = '0;
         for (int k = 0; k < S; k++) hist[k] = 0;
      end else begin
         m_err = 0;
         if (m_pend) begin
            if (acks == m_phase) begin
               m_pend = 0;
               m_cnt  = m_cnt + 16'd1;
            end
         end else if (acks != m_phase) begin
            m_err   = 1;
            m_phase = acks;
         end else if (in_valid_a && m_ready) begin
            for (int i = 0; i < 2; i++) begin
               dg = (int'(in_data_a) >> i) & 1;
               m_out[2*i + dg] = ~m_out[2*i + dg];
            end
            m_phase = ~m_phase;
            m_pend  = 1;
         end
         m_ready = !m_pend && (hist[S-1] == m_phase);
      end
   end

   // Compare every cycle, just after the edge has settled.
   always @(posedge clk) begin
      #1;
      if (mdl_en) begin
         chk("mdl_out",      out_a,      m_out);
         chk("mdl_in_ready", in_ready_a, m_ready);
         chk("mdl_busy",     busy_a,     m_pend);
         chk("mdl_err",      err_a,      m_err);
         chk("mdl_tx_count", tx_a,       m_cnt);
      end
   end

   task automatic send_a(input logic [1:0] d);
      in_valid_a = 1'b1;
      in_data_a  = d;
      @(negedge clk);
      in_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [3:0] d);
      in_valid_b = 1'b1;
      in_data_b  = d;
      @(negedge clk);
      in_valid_b = 1'b0;
   endtask

   task automatic wait_ready(input bit use_b, input string name);
      int n;
      n = 0;
      while (((use_b ? in_ready_b : in_ready_a) !== 1'b1) && n < S + 3) begin
         @(negedge clk);
         n++;
      end
      chk(name, use_b ? in_ready_b : in_ready_a, 1'b1);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   int        err_cnt;
   bit        acked;
   logic [3:0] prev_out;

   initial begin
      rst = 1'b1;
      in_valid_a = 0; in_data_a = '0; ack_a = 0;
      in_valid_b = 0; in_data_b = '0; ack_b = 0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready_a, 1'b0);
      mdl_en = 1;

      // Reset release
      rst = 1'b0;
      @(negedge clk);
      chk("rel_out",      out_a,      4'b0000);
      chk("rel_tx",       tx_a,       16'd0);
      chk("rel_busy",     busy_a,     1'b0);
      chk("rel_err",      err_a,      1'b0);
      chk("rel_in_ready", in_ready_a, 1'b1);

      // First token 2'b10
      send_a(2'b10);
      chk("t1_out",      out_a,      4'b1001);
      chk("t1_busy",     busy_a,     1'b1);
      chk("t1_in_ready", in_ready_a, 1'b0);
      ack_a = 1'b1;
      wait_ready(0, "t1_ready_rise");
      chk("t1_tx", tx_a, 16'd1);

      // Second token with in_valid held through WAIT_ACK
      in_valid_a = 1'b1;
      in_data_a  = 2'b01;
      @(negedge clk);
      chk("t2_out", out_a, 4'b1111);
      repeat (3) begin
         @(negedge clk);
         chk("t2_hold_out", out_a, 4'b1111);
      end
      in_valid_a = 1'b0;
      ack_a = 1'b0;
      wait_ready(0, "t2_ready_rise");
      chk("t2_tx", tx_a, 16'd2);

      // Spurious ack while idle
      err_cnt = 0;
      ack_a = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (err_a) err_cnt++;
      end
      chk("sp_err_cycles", err_cnt, 1);
      chk("sp_out",        out_a,   4'b1111);
      chk("sp_in_ready",   in_ready_a, 1'b1);
      send_a(2'b00);
      chk("sp_next_out", out_a, 4'b1010);
      err_cnt = 0;
      ack_a = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (err_a) err_cnt++;
      end
      chk("sp_next_err", err_cnt, 0);
      chk("sp_next_tx",  tx_a,    16'd3);

      // Reset during WAIT_ACK
      pulse_rst();
      send_a(2'b10);
      chk("mr_out_pre", out_a, 4'b1001);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_out",  out_a,  4'b0000);
      chk("mr_busy", busy_a, 1'b0);
      chk("mr_tx",   tx_a,   16'd0);
      rst = 1'b0;
      @(negedge clk);
      send_a(2'b11);
      chk("mr_next_out", out_a, 4'b1010);
      ack_a = 1'b1;
      wait_ready(0, "mr_ready_rise");
      chk("mr_next_tx", tx_a, 16'd1);

      // Three-rail instance: out-of-range digit, then digit value 2
      send_b(4'b0011);
      chk("b_bad_err",   err_b,      1'b1);
      chk("b_bad_out",   out_b,      6'b000000);
      chk("b_bad_ready", in_ready_b, 1'b1);
      chk("b_bad_busy",  busy_b,     1'b0);
      @(negedge clk);
      chk("b_bad_err_end", err_b, 1'b0);
      chk("b_bad_tx",      tx_b,  2'd0);
      send_b({2'd2, 2'd2});
      chk("b_d2_out",  out_b,  6'b100100);
      chk("b_d2_busy", busy_b, 1'b1);
      ack_b = 1'b1;
      wait_ready(1, "b_ready_rise");
      chk("b_tx1", tx_b, 2'd1);
      // d0=1, d1=0 -> bits 1 and 3
      send_b({2'd0, 2'd1});
      chk("b_t2_out", out_b, 6'b101110);
      ack_b = 1'b0;
      wait_ready(1, "b_ready_rise2");
      // Counter wrap on the 2-bit instance: 2 -> 3 -> 0
      for (int t = 0; t < 2; t++) begin
         send_b({2'd0, 2'd0});
         ack_b = ~ack_b;
         wait_ready(1, "b_wrap_ready");
      end
      chk("b_wrap_tx", tx_b, 2'd0);

      // Randomised traffic on instance A against the model
      ack_a = 1'b0;
      pulse_rst();
      prev_out = out_a;
      acked = 0;
      repeat (400) begin
         @(negedge clk);
         if (out_a != prev_out) begin
            prev_out = out_a;
            acked = 0;
         end
         in_valid_a = 1'($urandom % 2);
         in_data_a  = 2'($urandom);
         if (busy_a && !acked && ($urandom % 3 == 0)) begin
            ack_a = ~ack_a;
            acked = 1;
         end else if (!busy_a && ($urandom % 30 == 0)) begin
            ack_a = ~ack_a;
         end
      end
      in_valid_a = 1'b0;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/el_sync_tx.md
Name: el_sync_tx

Overview:
- Synchronous-to-asynchronous transmitter that injects tokens into the head of an elastic (el_pipeline) link.
- Accepts binary words on a clocked valid/ready interface.
- Encodes each digit 1-of-RAIL_NUM and drives it onto the link using 2-phase (transition) signalling.
- Waits for the downstream ack toggle, synchronised into clk, before accepting the next word.

Parameters:
- LINK_WIDTH, 2: number of digits per token.
- RAIL_NUM, 2: rails per digit (1-of-RAIL_NUM code).
- SYNC_STAGES, 2: flop stages on the asynchronous ack_i input; legal values are 2 or more.
- CNT_W, 16: width of the tx_count token counter.
- Derived, not overridable: DIGIT_W = max(1, clog2(RAIL_NUM)).

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  word offered on in_data.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  LINK_WIDTH*DIGIT_W  digit i occupies [DIGIT_W*i +: DIGIT_W].
- out  out  LINK_WIDTH*RAIL_NUM  link rails; rail r of digit i is bit RAIL_NUM*i+r.
- ack_i  in  1  asynchronous ack from the link; it toggles once per consumed token.
- busy  out  1  a token is outstanding (WAIT_ACK state).
- err  out  1  one-cycle pulse on a protocol or encoding error.
- tx_count  out  CNT_W  number of acknowledged tokens; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge): the following clear together.
  - out=0, phase_exp=0, sync chain=0.
  - state=IDLE, busy=0, err=0, tx_count=0.
  - in_ready is 0 while rst=1.
- States:
  - IDLE: in_ready=1, busy=0.
  - WAIT_ACK: in_ready=0, busy=1.
- Accept (IDLE, in_valid=1, all digits < RAIL_NUM):
  - At the next edge, out <= out ^ onehot_mask, where the mask has exactly one bit per digit: bit RAIL_NUM*i + in_data digit i.
  - At the same edge: phase_exp <= ~phase_exp and state -> WAIT_ACK.
  - All digit transitions appear in the same cycle. Latency from accept edge to out change is 1 clk.
- Out-of-range digit (any digit >= RAIL_NUM; only possible when RAIL_NUM is not a power of 2):
  - The word is consumed (in_ready=1) and dropped.
  - out is unchanged, err pulses 1 cycle, state stays IDLE.
- WAIT_ACK:
  - ack_s is ack_i after SYNC_STAGES flops.
  - When ack_s == phase_exp: state -> IDLE, tx_count <= tx_count+1, no err.
  - in_ready rises SYNC_STAGES+1 edges after the ack_i toggle, ±1 cycle.
  - out is held stable for the whole state.
- Spurious ack (IDLE and ack_s != phase_exp):
  - err pulses 1 cycle and phase_exp <= ack_s (resync).
  - If in_valid=1 in that same cycle, the word is not accepted; in_ready=0 for that cycle.
- in_valid while in WAIT_ACK: ignored; the upstream holds the word.
- in_data is sampled only on the accept edge; later changes have no effect.
- Reset mid-operation: out returns to 0 at the reset edge, with no partial-token recovery. rst is shared with the el_pipeline, so both ends restart at phase 0.
- tx_count wraps from 2^CNT_W-1 to 0 with no flag.
- Every output is registered: out, in_ready, busy, err, tx_count.

Decomposition:
- Shared package el_pkg:
  - function clog2;
  - state enum {IDLE, WAIT_ACK};
  - rail-index helper rail_bit(i, r) = RAIL_NUM*i + r.
  - The future el_sync_rx (receive side) uses the same package.
- Sub-module el_sync_bit: a parameterised SYNC_STAGES flop synchroniser with reset to 0, instantiated once for ack_i.

Test Plan:
All scenarios use defaults (LINK_WIDTH=2, RAIL_NUM=2) unless stated.
1. Reset then release -> out=4'b0000, tx_count=0, busy=0, err=0; in_ready=1 on the first cycle after rst falls.
2. Send in_data=2'b10 (d0=0, d1=1) -> one clk later out=4'b1001, in_ready=0, busy=1. Toggle ack_i 0->1 -> in_ready=1 within SYNC_STAGES+2 cycles, tx_count=1.
3. Send in_data=2'b01 next -> out=4'b1111. Ack 1->0 -> tx_count=2. Hold in_valid throughout WAIT_ACK -> out does not change a second time.
4. Toggle ack_i while IDLE -> err high for exactly 1 cycle, out unchanged. The next token plus a proper ack completes without error.
5. Assert rst during WAIT_ACK with out=4'b1001 -> out=0, busy=0, tx_count=0 at the reset edge; a normal token follows correctly.
6. RAIL_NUM=3, send digit value 3 -> err pulse, out unchanged, tx_count unchanged, state IDLE. Digit value 2 -> bit 2 (d0) or bit 5 (d1) toggles.
